// File: rtl/mx_int8_block_seq.sv
// MXINT8 block sequencer: gathers BLOCK_SIZE FP32 elements, picks the largest
// biased exponent as the shared E8M0 scale, walks the external FP32->INT8
// converter over the buffered block, then holds the finished block on a
// valid/ready output until the consumer takes it.
module mx_int8_block_seq #(
    parameter int BLOCK_SIZE = 32,
    parameter int FP_W       = 32,
    parameter int SCALE_W    = 8,
    parameter int ELEM_W     = 8,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [FP_W-1:0]              in_data,
    output logic                         cvt_req,
    output logic [FP_W-1:0]              cvt_float,
    output logic [SCALE_W-1:0]           cvt_scale,
    input  logic [ELEM_W-1:0]            cvt_elem,
    input  logic                         cvt_overflow,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SCALE_W-1:0]           out_scale,
    output logic [BLOCK_SIZE*ELEM_W-1:0] out_elems,
    output logic                         out_overflow,
    output logic                         busy,
    output logic [CNT_W-1:0]             blocks_done
);

    localparam int IDX_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);
    // Biased exponent field sits directly below the sign bit.
    localparam int EXP_MSB = FP_W - 2;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_CONVERT = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     cnt_q, cnt_d;
    logic [SCALE_W-1:0]   max_exp_q, max_exp_d;
    logic                 ovf_q, ovf_d;
    logic                 out_valid_q, out_valid_d;
    logic                 cvt_req_q, cvt_req_d;
    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     blocks_done_q, blocks_done_d;
    logic [FP_W-1:0]      cvt_float_q, cvt_float_d;
    logic [SCALE_W-1:0]   cvt_scale_q, cvt_scale_d;

    // Element buffer (FP32 inputs) and result buffer (INT8 outputs).
    logic [FP_W-1:0]      buf_q  [BLOCK_SIZE];
    logic [ELEM_W-1:0]    obuf_q [BLOCK_SIZE];
    logic                 buf_we;
    logic                 obuf_we;

    logic [SCALE_W-1:0]   in_exp;
    logic [SCALE_W-1:0]   new_max;
    logic [IDX_W-1:0]     cnt_inc;

    assign in_exp  = in_data[EXP_MSB -: SCALE_W];
    // Zero/subnormal naturally give 0 and Inf/NaN give all-ones, so a plain
    // unsigned max over the raw exponent field is the scale rule.
    assign new_max = (in_exp > max_exp_q) ? in_exp : max_exp_q;
    assign cnt_inc = cnt_q + 1'b1;

    // Next-state and datapath control for the collect/convert/output sequence.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        max_exp_d     = max_exp_q;
        ovf_d         = ovf_q;
        out_valid_d   = out_valid_q;
        blocks_done_d = blocks_done_q;
        cvt_float_d   = cvt_float_q;
        cvt_scale_d   = cvt_scale_q;
        buf_we        = 1'b0;
        obuf_we       = 1'b0;

        unique case (state_q)
            ST_COLLECT: begin
                if (flush) begin
                    // Abort wins over a same-cycle handshake.
                    cnt_d     = '0;
                    max_exp_d = '0;
                end else if (in_valid) begin
                    buf_we    = 1'b1;
                    max_exp_d = new_max;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d       = '0;
                        state_d     = ST_CONVERT;
                        // Element 0 was stored earlier, so it can be presented
                        // to the converter on the first CONVERT cycle.
                        cvt_float_d = buf_q[0];
                        cvt_scale_d = new_max;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            ST_CONVERT: begin
                obuf_we = 1'b1;
                ovf_d   = ovf_q | cvt_overflow;
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = ST_OUTPUT;
                end else begin
                    cnt_d       = cnt_inc;
                    cvt_float_d = buf_q[cnt_inc];
                end
            end

            ST_OUTPUT: begin
                if (!out_valid_q) begin
                    // Result buffer settles on entry; raise valid one cycle later.
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d   = 1'b0;
                    blocks_done_d = blocks_done_q + 1'b1;
                    max_exp_d     = '0;
                    ovf_d         = 1'b0;
                    state_d       = ST_COLLECT;
                end
            end

            default: begin
                state_d = ST_COLLECT;
                cnt_d   = '0;
            end
        endcase

        cvt_req_d = (state_d == ST_CONVERT);
        busy_d    = (state_d != ST_COLLECT);
    end

    // State, control and buffer registers; reset discards any block in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_COLLECT;
            cnt_q         <= '0;
            max_exp_q     <= '0;
            ovf_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            cvt_req_q     <= 1'b0;
            busy_q        <= 1'b0;
            blocks_done_q <= '0;
            cvt_float_q   <= '0;
            cvt_scale_q   <= '0;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                buf_q[i]  <= '0;
                obuf_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            max_exp_q     <= max_exp_d;
            ovf_q         <= ovf_d;
            out_valid_q   <= out_valid_d;
            cvt_req_q     <= cvt_req_d;
            busy_q        <= busy_d;
            blocks_done_q <= blocks_done_d;
            cvt_float_q   <= cvt_float_d;
            cvt_scale_q   <= cvt_scale_d;
            if (buf_we) begin
                buf_q[cnt_q] <= in_data;
            end
            if (obuf_we) begin
                obuf_q[cnt_q] <= cvt_elem;
            end
        end
    end

    // Flatten the result buffer onto the output bus, element i at [i*ELEM_W +: ELEM_W].
    for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_pack
        assign out_elems[gi*ELEM_W +: ELEM_W] = obuf_q[gi];
    end

    assign in_ready     = rst_n && (state_q == ST_COLLECT);
    assign cvt_req      = cvt_req_q;
    assign cvt_float    = cvt_float_q;
    assign cvt_scale    = cvt_scale_q;
    assign out_valid    = out_valid_q;
    assign out_scale    = max_exp_q;
    assign out_overflow = ovf_q;
    assign busy         = busy_q;
    assign blocks_done  = blocks_done_q;

endmodule

// File: tb/tb_mx_int8_block_seq.sv
// Self-checking bench for mx_int8_block_seq: directed block scenarios plus
// randomized FP32 blocks, checked against a block-level reference model.
`timescale 1ns/1ps
module tb_mx_int8_block_seq;

    localparam int BS  = 32;
    localparam int LAT = BS + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_data = '0;
    logic            cvt_req;
    logic [31:0]     cvt_float;
    logic [7:0]      cvt_scale;
    logic [7:0]      cvt_elem;
    logic            cvt_overflow;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [7:0]      out_scale;
    logic [BS*8-1:0] out_elems;
    logic            out_overflow;
    logic            busy;
    logic [15:0]     blocks_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ovf_idx = -1;
    int conv_idx = 0;
    int exp_blocks = 0;
    logic [31:0] blk [BS];

    mx_int8_block_seq #(
        .BLOCK_SIZE(BS), .FP_W(32), .SCALE_W(8), .ELEM_W(8), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cvt_req(cvt_req), .cvt_float(cvt_float), .cvt_scale(cvt_scale),
        .cvt_elem(cvt_elem), .cvt_overflow(cvt_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_scale(out_scale),
        .out_elems(out_elems), .out_overflow(out_overflow),
        .busy(busy), .blocks_done(blocks_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Converter stub: INT8 with 6 fractional bits, value = x / 2^(scale-127).
    function automatic logic [7:0] conv(input logic [31:0] f, input logic [7:0] s);
        int e, sh, mag;
        logic [23:0] m;
        e  = int'(f[30:23]);
        m  = {1'b1, f[22:0]};
        sh = int'(s) - e + 17;
        if (e == 0)       mag = 0;
        else if (sh < 0)  mag = 127;
        else if (sh > 23) mag = 0;
        else              mag = int'(m >> sh);
        if (mag > 127) mag = 127;
        return f[31] ? 8'(-mag) : 8'(mag);
    endfunction

    assign cvt_elem     = conv(cvt_float, cvt_scale);
    assign cvt_overflow = cvt_req && (conv_idx == ovf_idx);

    // Index of the element the converter is being asked about.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       conv_idx <= 0;
        else if (cvt_req) conv_idx <= conv_idx + 1;
        else              conv_idx <= 0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rnd_fp(input int lo, input int hi);
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        s = 1'($urandom_range(0, 1));
        e = 8'($urandom_range(lo, hi));
        m = 23'($urandom);
        return {s, e, m};
    endfunction

    task automatic fill_const(input logic [31:0] v);
        for (int i = 0; i < BS; i++) blk[i] = v;
    endtask

    task automatic fill_rand(input int lo, input int hi);
        for (int i = 0; i < BS; i++) blk[i] = rnd_fp(lo, hi);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_blocks_done", 256'(blocks_done), 256'(0));
        rst_n = 1'b1;
        exp_blocks = 0;
        #1;
        check("rst_in_ready", 256'(in_ready), 256'(1));
    endtask

    // Stream blk[] in, follow the conversion, then take the block after `hold` stalled cycles.
    task automatic run_block(input string name, input int hold, input int want_scale);
        logic [7:0]    exp_scale;
        logic [255:0]  exp_elems;
        logic          exp_ovf;
        int            t_last, k, lat;
        bit            seen;

        exp_scale = 8'h00;
        for (int i = 0; i < BS; i++)
            if (blk[i][30:23] > exp_scale) exp_scale = blk[i][30:23];
        exp_elems = '0;
        for (int i = 0; i < BS; i++) exp_elems[i*8 +: 8] = conv(blk[i], exp_scale);
        exp_ovf = (ovf_idx >= 0) && (ovf_idx < BS);

        out_ready = (hold == 0);
        for (int i = 0; i < BS; i++) begin
            in_valid = 1'b1;
            in_data  = blk[i];
            if (i == 0) check({name, "_in_ready"}, 256'(in_ready), 256'(1));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        t_last = cyc;

        k = 0;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            if (cvt_req) begin
                if (k < BS) begin
                    check({name, "_cvt_float"}, 256'(cvt_float), 256'(blk[k]));
                    check({name, "_cvt_scale"}, 256'(cvt_scale), 256'(exp_scale));
                end
                k++;
            end
            if (out_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        lat = cyc - t_last;
        check({name, "_out_valid_seen"}, 256'(seen), 256'(1));
        check({name, "_latency"}, 256'(lat), 256'(LAT));
        check({name, "_cvt_cycles"}, 256'(k), 256'(BS));
        check({name, "_scale"}, 256'(out_scale), 256'(exp_scale));
        if (want_scale >= 0) check({name, "_scale_spec"}, 256'(out_scale), 256'(want_scale));
        check({name, "_elems"}, out_elems, exp_elems);
        check({name, "_overflow"}, 256'(out_overflow), 256'(exp_ovf));
        check({name, "_busy"}, 256'(busy), 256'(1));
        check({name, "_in_ready_out"}, 256'(in_ready), 256'(0));

        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({name, "_hold_valid"}, 256'(out_valid), 256'(1));
            check({name, "_hold_elems"}, out_elems, exp_elems);
            check({name, "_hold_scale"}, 256'(out_scale), 256'(exp_scale));
            check({name, "_hold_ovf"}, 256'(out_overflow), 256'(exp_ovf));
            check({name, "_hold_in_ready"}, 256'(in_ready), 256'(0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_blocks++;
        check({name, "_valid_drop"}, 256'(out_valid), 256'(0));
        check({name, "_blocks_done"}, 256'(blocks_done), 256'(16'(exp_blocks)));
        check({name, "_busy_idle"}, 256'(busy), 256'(0));
        check({name, "_in_ready_idle"}, 256'(in_ready), 256'(1));
        $display("block %s: scale=%h overflow=%0d latency=%0d blocks_done=%0d",
                 name, out_scale, exp_ovf, lat, blocks_done);
    endtask

    initial begin
        do_reset();

        // 1) all 1.0
        fill_const(32'h3F800000);
        run_block("t1_ones", 0, 8'h7F);

        // 2) 1.0 with a single 4.0
        fill_const(32'h3F800000);
        blk[$urandom_range(0, BS-1)] = 32'h40800000;
        run_block("t2_four", 0, 8'h81);

        // 3) all zero, then zeros with one Inf
        fill_const(32'h00000000);
        run_block("t3_zero", 0, 8'h00);
        fill_const(32'h00000000);
        blk[$urandom_range(0, BS-1)] = 32'h7F800000;
        run_block("t3_inf", 0, 8'hFF);

        // 4) overflow on element 5 only, then a clean block
        ovf_idx = 5;
        fill_rand(100, 140);
        run_block("t4_ovf", 0, -1);
        ovf_idx = -1;
        fill_rand(100, 140);
        run_block("t4_clean", 0, -1);

        // randomized blocks with random consumer stalls
        for (int r = 0; r < 4; r++) begin
            fill_rand(90, 150);
            run_block("rand", int'($urandom_range(0, 3)), -1);
        end

        // 5) partial block, flush with same-cycle valid, then a block of 2.0
        do_reset();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = rnd_fp(200, 220);
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        in_data = 32'h7F000000;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("t5_in_ready_after_flush", 256'(in_ready), 256'(1));
        fill_const(32'h40000000);
        run_block("t5_flush", 0, 8'h80);

        // 6) long stall, then reset in the middle of conversion
        fill_rand(110, 130);
        run_block("t6_stall", 20, -1);
        fill_rand(110, 130);
        for (int i = 0; i < BS; i++) begin
            in_valid = 1'b1;
            in_data  = blk[i];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("t6_mid_cvt_req", 256'(cvt_req), 256'(1));
        rst_n = 1'b0;
        #1;
        check("t6_rst_cvt_req", 256'(cvt_req), 256'(0));
        check("t6_rst_busy", 256'(busy), 256'(0));
        check("t6_rst_out_valid", 256'(out_valid), 256'(0));
        check("t6_rst_blocks_done", 256'(blocks_done), 256'(0));
        check("t6_rst_scale", 256'(out_scale), 256'(0));
        check("t6_rst_elems", out_elems, 256'(0));
        check("t6_rst_ovf", 256'(out_overflow), 256'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_blocks = 0;
        #1;
        check("t6_in_ready_release", 256'(in_ready), 256'(1));
        fill_rand(100, 140);
        run_block("t6_recover", 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
